// File: rtl/lsu_mem_initiator.sv
// Load/store front end: one request at a time is turned into a word-aligned memory access and a single response.
// Optional macro LSU_TIMEOUT_EN aborts a REQ that waits TIMEOUT_CYCLES cycles without d_ready.
module lsu_mem_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [31:0] d_addr,
    output logic        d_wen,
    output logic [31:0] d_wdata,
    output logic [7:0]  wmask,
    input  logic [31:0] d_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    // Valid/ready: a transfer happens on a rising edge where valid and ready are both high;
    // valid, once raised, stays high with stable payload until that edge.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  mask_q, mask_d;
    logic        wen_q, wen_d;
    logic        err_q, err_d;
    logic        uns_q, uns_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;

    logic        req_bad;
    logic [3:0]  lane_mask;
    logic [31:0] shifted;
    logic [31:0] load_data;
    logic        timeout;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES < 256) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Terminal count is the last REQ cycle; d_ready in that cycle still completes normally.
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q != S_REQ) begin
            cnt_d = '0;
        end else if (!d_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        req_bad = (req_size == 2'd3) ||
                  ((req_size == 2'd1) && req_addr[0]) ||
                  ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));

        case (req_size)
            2'd0:    lane_mask = 4'b0001 << req_addr[1:0];
            2'd1:    lane_mask = 4'b0011 << req_addr[1:0];
            2'd2:    lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase

        shifted = d_rdata >> {off_q, 3'b000};
        case (size_q)
            2'd0:    load_data = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
            2'd1:    load_data = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        mask_d  = mask_q;
        wen_d   = wen_q;
        err_d   = err_q;
        uns_d   = uns_q;
        size_d  = size_q;
        off_d   = off_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = {req_addr[31:2], 2'b00};
                    wdata_d = req_wdata << {req_addr[1:0], 3'b000};
                    mask_d  = req_store ? lane_mask : 4'b0000;
                    wen_d   = req_store;
                    size_d  = req_size;
                    off_d   = req_addr[1:0];
                    uns_d   = req_unsigned;
                    rdata_d = '0;
                    err_d   = req_bad;
                    state_d = req_bad ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                if (d_ready) begin
                    rdata_d = wen_q ? 32'h0 : load_data;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (timeout) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            mask_q  <= '0;
            wen_q   <= 1'b0;
            err_q   <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= '0;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            mask_q  <= mask_d;
            wen_q   <= wen_d;
            err_q   <= err_d;
            uns_q   <= uns_d;
            size_q  <= size_d;
            off_q   <= off_d;
        end
    end

    // Payload is forced to zero outside its valid window so idle buses carry no stale data.
    assign req_ready  = (state_q == S_IDLE);
    assign d_valid    = (state_q == S_REQ);
    assign d_addr     = d_valid ? addr_q : 32'h0;
    assign d_wen      = d_valid & wen_q;
    assign d_wdata    = d_valid ? wdata_q : 32'h0;
    assign wmask      = {4'b0000, (d_valid ? mask_q : 4'b0000)};
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = resp_valid ? rdata_q : 32'h0;
    assign resp_err   = resp_valid & err_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Bench for lsu_mem_initiator: directed cases plus random traffic checked against a byte-lane reference model.
// Build with LSU_TIMEOUT_EN defined to exercise the timeout path with a 4-cycle limit.
module tb_lsu_mem_initiator;

`ifdef LSU_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        d_valid;
    logic        d_ready;
    logic [31:0] d_addr;
    logic        d_wen;
    logic [31:0] d_wdata;
    logic [7:0]  wmask;
    logic [31:0] d_rdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    lsu_mem_initiator #(.TIMEOUT_CYCLES((TMO == 0) ? 255 : TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_store(req_store), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_wen(d_wen),
        .d_wdata(d_wdata), .wmask(wmask), .d_rdata(d_rdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    // Clock and time bound
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: lane arithmetic straight from the access rules.
    function automatic void model(input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] rdata, input logic store,
                                  input logic [1:0] size, input logic uns,
                                  output bit err, output logic [31:0] e_addr,
                                  output logic [31:0] e_wdata, output logic [31:0] e_rdata,
                                  output logic [7:0] e_mask);
        int off;
        int nb;
        longint val;
        off = int'(addr % 4);
        nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        err = (size == 2'd3) || ((off % nb) != 0);
        e_addr  = addr - 32'(off);
        e_wdata = 32'((longint'(wdata) * (longint'(1) << (8 * off))) % (longint'(1) << 32));
        e_mask  = 8'h00;
        if (store && !err)
            for (int i = 0; i < 4; i++)
                if (i >= off && i < off + nb) e_mask = e_mask + 8'(1 << i);
        val = longint'(rdata) / (longint'(1) << (8 * off));
        val = val % (longint'(1) << (8 * nb));
        if (!uns && nb < 4 && val >= (longint'(1) << (8 * nb - 1)))
            val = val - (longint'(1) << (8 * nb));
        e_rdata = (store || err) ? 32'h0 : 32'(val);
    endfunction

    // Driver: one complete transaction with given memory and writeback stall lengths.
    task automatic do_txn(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input logic store,
                          input logic [1:0] size, input logic uns,
                          input int d_dly, input int r_dly);
        bit err;
        bit tmo;
        int req_cycles;
        logic [31:0] ea, ew, er, exp_r;
        logic [7:0] em;
        model(addr, wdata, rdata, store, size, uns, err, ea, ew, er, em);
        tmo = (TMO != 0) && !err && (d_dly >= TMO);
        exp_q.push_back(tmo ? 32'h0 : er);

        chk("idle_req_ready", {31'h0, req_ready}, 32'h1);
        req_addr = addr; req_wdata = wdata; req_store = store;
        req_size = size; req_unsigned = uns; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr = $urandom; req_wdata = $urandom;

        if (!err) begin
            req_cycles = tmo ? TMO : d_dly + 1;
            for (int k = 0; k < req_cycles; k++) begin
                chk("d_valid", {31'h0, d_valid}, 32'h1);
                chk("d_addr", d_addr, ea);
                chk("d_wen", {31'h0, d_wen}, {31'h0, store});
                chk("d_wdata", d_wdata, ew);
                chk("wmask", {24'h0, wmask}, {24'h0, em});
                chk("req_ready_busy", {31'h0, req_ready}, 32'h0);
                chk("resp_valid_early", {31'h0, resp_valid}, 32'h0);
                req_valid = 1'($urandom_range(0, 1));
                if (!tmo && k == d_dly) begin
                    d_ready = 1'b1;
                    d_rdata = rdata;
                end
                @(posedge clk);
                @(negedge clk);
                d_ready = 1'b0;
                d_rdata = $urandom;
            end
        end

        exp_r = exp_q.pop_front();
        for (int k = 0; k <= r_dly; k++) begin
            chk("resp_valid", {31'h0, resp_valid}, 32'h1);
            chk("resp_rdata", resp_rdata, exp_r);
            chk("resp_err", {31'h0, resp_err}, {31'h0, (err || tmo)});
            chk("d_valid_resp", {31'h0, d_valid}, 32'h0);
            chk("d_wen_resp", {31'h0, d_wen}, 32'h0);
            chk("req_ready_resp", {31'h0, req_ready}, 32'h0);
            req_valid = 1'($urandom_range(0, 1));
            d_ready = 1'($urandom_range(0, 1));
            if (k == r_dly) resp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            resp_ready = 1'b0;
            req_valid = 1'b0;
            d_ready = 1'b0;
        end
        chk("back_to_idle", {30'h0, req_ready, resp_valid}, 32'h2);
    endtask

    logic [31:0] r_addr;
    logic [1:0]  r_size;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_store = 1'b0;
        req_size = '0; req_unsigned = 1'b0; d_ready = 1'b0; d_rdata = '0; resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_d_valid", {31'h0, d_valid}, 32'h0);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_d_addr", d_addr, 32'h0);
        chk("rst_wmask", {24'h0, wmask}, 32'h0);
        chk("rst_resp", {resp_rdata[30:0], resp_err}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        do_txn(32'h8000_0003, 32'h0000_00AB, 32'h0, 1'b1, 2'd0, 1'b0, 0, 0);
        do_txn(32'h8000_0002, 32'h0, 32'h8001_1234, 1'b0, 2'd1, 1'b0, 0, 0);
        do_txn(32'h8000_0002, 32'h0, 32'h8001_1234, 1'b0, 2'd1, 1'b1, 0, 0);
        do_txn(32'h8000_0001, 32'h0, 32'h1234_5678, 1'b0, 2'd2, 1'b0, 0, 0);
        do_txn(32'h8000_0003, 32'h0, 32'h0, 1'b1, 2'd1, 1'b0, 0, 1);
        do_txn(32'h8000_0000, 32'h0, 32'h0, 1'b0, 2'd3, 1'b0, 0, 0);
        do_txn(32'h8000_0010, 32'h0, 32'hCAFE_F00D, 1'b0, 2'd2, 1'b0, 5, 3);
        do_txn(32'h8000_0011, 32'h0, 32'h0000_8000, 1'b0, 2'd0, 1'b0, 3, 0);
        do_txn(32'h8000_0012, 32'h5555_BEEF, 32'h0, 1'b1, 2'd1, 1'b0, 4, 0);

        // Asynchronous reset while a load is outstanding
        req_addr = 32'h8000_0020; req_store = 1'b0; req_size = 2'd2; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("pre_rst_d_valid", {31'h0, d_valid}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_d_valid", {31'h0, d_valid}, 32'h0);
        chk("async_rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("async_rst_d_addr", d_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_txn(32'h8000_0024, 32'h0, 32'h0000_00F0, 1'b0, 2'd0, 1'b0, 0, 0);

        for (int t = 0; t < 60; t++) begin
            r_addr = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
            r_size = 2'($urandom_range(0, 3));
            do_txn(r_addr, $urandom, $urandom, 1'($urandom_range(0, 1)), r_size,
                   1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
